ps2_direction_rx: RTL

PS/2 keyboard receiver and scan-code decoder for the snake game: samples the keyboard's PS/2 clock/data lines and checks each 11-bit frame. It decodes arrow keys and WASD into one-cycle direction pulses. Outputs match the push-button key module's press-pulse interface, so the game controller and snake modules can take either source, or an OR of both, without change.

---
 rtl/ps2_direction_rx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ps2_direction_rx.sv
// PS/2 keyboard receiver: frames 11-bit words off the PS/2 lines and turns arrow/WASD
// make codes into one-cycle direction pulses matching the push-button key interface.
module ps2_direction_rx #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       left_key_press,
   output logic       right_key_press,
   output logic       up_key_press,
   output logic       down_key_press,
   output logic [7:0] scan_code,
   output logic       code_valid,
   output logic       frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

   state_t        state, state_next;
   logic          clk_s1, clk_s2, clk_prev, data_s1, data_s2;
   logic          fall;
   logic [3:0]    bit_cnt, bit_cnt_next;
   logic [9:0]    shift, shift_next;
   logic [TW-1:0] tcnt, tcnt_next;
   logic          ext, ext_next, brk, brk_next;
   logic [3:0]    held, held_next;
   logic [3:0]    dir_q, dir_next;
   logic [7:0]    scan_next;
   logic          valid_next, err_next;
   logic          frame_ok;
   logic          dir_hit;
   logic [1:0]    dir_idx;

   // Idle-high bus, so the synchronizer and edge register come out of reset at 1
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         clk_prev <= 1'b1;
         data_s1  <= 1'b1;
         data_s2  <= 1'b1;
      end else begin
         clk_s1   <= ps2_clk;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         data_s1  <= ps2_data;
         data_s2  <= data_s1;
      end
   end

   assign fall     = clk_prev & ~clk_s2;
   assign frame_ok = (^shift[8:0]) & shift[9];

   // Direction index: 0 left, 1 right, 2 up, 3 down
   always_comb begin
      dir_hit = 1'b1;
      dir_idx = 2'd0;
      unique case ({ext, shift[7:0]})
         {1'b1, 8'h6B}, {1'b0, 8'h1C}: dir_idx = 2'd0;
         {1'b1, 8'h74}, {1'b0, 8'h23}: dir_idx = 2'd1;
         {1'b1, 8'h75}, {1'b0, 8'h1D}: dir_idx = 2'd2;
         {1'b1, 8'h72}, {1'b0, 8'h1B}: dir_idx = 2'd3;
         default:                      dir_hit = 1'b0;
      endcase
   end

   always_comb begin
      state_next   = state;
      bit_cnt_next = bit_cnt;
      shift_next   = shift;
      tcnt_next    = tcnt;
      ext_next     = ext;
      brk_next     = brk;
      held_next    = held;
      scan_next    = scan_code;
      valid_next   = 1'b0;
      err_next     = 1'b0;
      dir_next     = 4'b0000;
      unique case (state)
         IDLE: begin
            if (fall) begin
               if (!data_s2) begin
                  state_next   = RECV;
                  bit_cnt_next = 4'd0;
                  tcnt_next    = '0;
               end else begin
                  err_next = 1'b1;
                  ext_next = 1'b0;
                  brk_next = 1'b0;
               end
            end
         end
         RECV: begin
            if (fall) begin
               tcnt_next  = '0;
               shift_next = {data_s2, shift[9:1]};
               if (bit_cnt == 4'd9) state_next = CHECK;
               else bit_cnt_next = bit_cnt + 4'd1;
            end else if (tcnt >= TMAX) begin
               state_next = IDLE;
               err_next   = 1'b1;
               ext_next   = 1'b0;
               brk_next   = 1'b0;
            end else if (tcnt != '1) begin
               tcnt_next = tcnt + 1'b1;
            end
         end
         CHECK: begin
            state_next = IDLE;
            if (frame_ok) begin
               scan_next  = shift[7:0];
               valid_next = 1'b1;
               if (shift[7:0] == 8'hE0) begin
                  ext_next = 1'b1;
               end else if (shift[7:0] == 8'hF0) begin
                  brk_next = 1'b1;
               end else begin
                  ext_next = 1'b0;
                  brk_next = 1'b0;
                  // A make on an already-held direction is typematic repeat and stays silent
                  if (dir_hit) begin
                     if (brk) begin
                        held_next[dir_idx] = 1'b0;
                     end else if (!held[dir_idx]) begin
                        dir_next[dir_idx]  = 1'b1;
                        held_next[dir_idx] = 1'b1;
                     end
                  end
               end
            end else begin
               err_next = 1'b1;
               ext_next = 1'b0;
               brk_next = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         bit_cnt    <= 4'd0;
         shift      <= 10'd0;
         tcnt       <= '0;
         ext        <= 1'b0;
         brk        <= 1'b0;
         held       <= 4'b0000;
         dir_q      <= 4'b0000;
         scan_code  <= 8'h00;
         code_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_next;
         bit_cnt    <= bit_cnt_next;
         shift      <= shift_next;
         tcnt       <= tcnt_next;
         ext        <= ext_next;
         brk        <= brk_next;
         held       <= held_next;
         dir_q      <= dir_next;
         scan_code  <= scan_next;
         code_valid <= valid_next;
         frame_err  <= err_next;
      end
   end

   assign left_key_press  = dir_q[0];
   assign right_key_press = dir_q[1];
   assign up_key_press    = dir_q[2];
   assign down_key_press  = dir_q[3];

endmodule
